rtc_bus_transaction_controller: RTL and testbench

- Upstream command sequencer for the RTC parallel-bus control-signal generator.
- Queues read/write commands and launches one generator cycle per command via en_funcion/in_escribir_leer.
- Drives and samples the multiplexed 8-bit AD bus using the generator's a_d/cs/rd/direction outputs.
- Returns read data or write completion, and pulses the generator's reset so it re-arms after each flag_done.

---
 rtl/rtc_bus_transaction_controller.sv | 169 ++++++++++++++++
 tb/tb_rtc_bus_transaction_controller.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_transaction_controller.sv
// Command sequencer for the RTC parallel-bus generator: queues read/write commands,
// launches one generator cycle per command, steers the AD bus and returns responses.
module rtc_bus_transaction_controller #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT        = 32,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset_count,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       gen_en_funcion,
    output logic       gen_escribir_leer,
    output logic       gen_reset,
    input  logic       gen_a_d,
    input  logic       gen_cs,
    input  logic       gen_rd,
    input  logic       gen_dir_dato,
    input  logic       gen_flag_done,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       rsp_valid,
    output logic       rsp_write,
    output logic [7:0] rsp_rdata,
    output logic       rsp_error,
    output logic       busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int RW = $clog2(RECOVER_CYCLES + 1);
    localparam logic [5:0]    TMO_LAST = 6'(TIMEOUT - 1);
    localparam logic [RW-1:0] REC_INIT = RW'(RECOVER_CYCLES);

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RECOVER} state_t;

    cmd_t          r_mem [DEPTH];
    logic [AW:0]   r_wptr, r_rptr;
    state_t        r_state;
    cmd_t          r_act;
    logic [5:0]    r_tmo;
    logic [RW-1:0] r_rec;
    logic [7:0]    r_shadow;
    logic          r_gen_en, r_gen_wr, r_gen_reset;
    logic          r_rsp_valid, r_rsp_write, r_rsp_error;
    logic [7:0]    r_rsp_rdata;

    logic w_full, w_empty, w_push, w_pop, w_capture;
    cmd_t w_head;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push    = cmd_valid && !w_full;
    assign w_pop     = (r_state == IDLE) && !w_empty;
    assign w_head    = r_mem[r_rptr[AW-1:0]];
    assign w_capture = (r_state == WAIT) && !r_act.wr && gen_dir_dato && !gen_cs && !gen_rd;

    assign cmd_ready         = !w_full;
    assign busy              = (r_state != IDLE) || !w_empty;
    assign gen_en_funcion    = r_gen_en;
    assign gen_escribir_leer = r_gen_wr;
    assign gen_reset         = r_gen_reset;
    assign rsp_valid         = r_rsp_valid;
    assign rsp_write         = r_rsp_write;
    assign rsp_rdata         = r_rsp_rdata;
    assign rsp_error         = r_rsp_error;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= {cmd_write, cmd_addr, cmd_wdata};
    end

    always_ff @(posedge clk or posedge reset_count) begin
        if (reset_count) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_state     <= RECOVER;
            r_act       <= '0;
            r_tmo       <= '0;
            r_rec       <= REC_INIT;
            r_shadow    <= '0;
            r_gen_en    <= 1'b0;
            r_gen_wr    <= 1'b0;
            r_gen_reset <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_gen_en    <= 1'b0;
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_act    <= w_head;
                        r_gen_wr <= w_head.wr;
                        r_gen_en <= 1'b1;
                        r_state  <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    r_tmo    <= '0;
                    r_shadow <= '0;
                    r_state  <= WAIT;
                end
                WAIT: begin
                    if (w_capture) r_shadow <= ad_in;
                    // flag_done takes priority over a timeout landing in the same cycle
                    if (gen_flag_done) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_write <= r_act.wr;
                        r_rsp_error <= 1'b0;
                        r_rsp_rdata <= r_act.wr ? 8'h00 : r_shadow;
                        r_rec       <= REC_INIT;
                        r_gen_reset <= 1'b1;
                        r_state     <= RECOVER;
                    end else if (r_tmo == TMO_LAST) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_write <= r_act.wr;
                        r_rsp_error <= 1'b1;
                        r_rsp_rdata <= 8'h00;
                        r_rec       <= REC_INIT;
                        r_gen_reset <= 1'b1;
                        r_state     <= RECOVER;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                RECOVER: begin
                    if (r_rec == RW'(1)) begin
                        r_gen_reset <= 1'b0;
                        r_gen_wr    <= 1'b0;
                        r_state     <= IDLE;
                    end else begin
                        r_rec <= r_rec - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Bus steering follows the generator phase signals only while a cycle is in flight.
    always_comb begin
        ad_oe  = 1'b0;
        ad_out = 8'h00;
        if (r_state == WAIT) begin
            if (!gen_dir_dato && !gen_a_d) begin
                ad_oe  = 1'b1;
                ad_out = r_act.addr;
            end else if (gen_dir_dato && r_act.wr) begin
                ad_oe  = 1'b1;
                ad_out = r_act.wdata;
            end
        end
    end

endmodule

// File: tb/tb_rtc_bus_transaction_controller.sv
// Directed bench for rtc_bus_transaction_controller with a hand-stepped generator model.
module tb_rtc_bus_transaction_controller;

    logic       clk = 1'b0;
    logic       reset_count;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [7:0] cmd_addr, cmd_wdata;
    logic       gen_en_funcion, gen_escribir_leer, gen_reset;
    logic       gen_a_d, gen_cs, gen_rd, gen_dir_dato, gen_flag_done;
    logic [7:0] ad_in, ad_out;
    logic       ad_oe;
    logic       rsp_valid, rsp_write, rsp_error;
    logic [7:0] rsp_rdata;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;

    rtc_bus_transaction_controller #(.DEPTH(4), .TIMEOUT(32), .RECOVER_CYCLES(2)) dut (
        .clk(clk), .reset_count(reset_count),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .gen_en_funcion(gen_en_funcion), .gen_escribir_leer(gen_escribir_leer),
        .gen_reset(gen_reset), .gen_a_d(gen_a_d), .gen_cs(gen_cs), .gen_rd(gen_rd),
        .gen_dir_dato(gen_dir_dato), .gen_flag_done(gen_flag_done),
        .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic gen_idle();
        gen_a_d = 1'b1; gen_cs = 1'b1; gen_rd = 1'b1;
        gen_dir_dato = 1'b0; gen_flag_done = 1'b0;
    endtask

    task automatic offer(input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    endtask

    task automatic expect_launch(input logic wr, input string tag);
        tick();
        chk({tag, ".en"}, 32'(gen_en_funcion), 32'd1);
        chk({tag, ".sel"}, 32'(gen_escribir_leer), 32'(wr));
    endtask

    // Called in LAUNCH or an idle WAIT cycle; returns in the IDLE cycle after recovery.
    task automatic gen_txn(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                           input logic [7:0] rdval, input string tag);
        tick();
        cmd_valid = 1'b0;
        gen_a_d = 1'b0; gen_cs = 1'b0; gen_rd = 1'b1; gen_dir_dato = 1'b0;
        settle();
        chk({tag, ".en_pulse"}, 32'(gen_en_funcion), 32'd0);
        chk({tag, ".addr_oe"}, 32'(ad_oe), 32'd1);
        chk({tag, ".addr_out"}, 32'(ad_out), 32'(addr));
        chk({tag, ".sel"}, 32'(gen_escribir_leer), 32'(wr));
        tick();
        gen_a_d = 1'b1; gen_cs = 1'b1;
        settle();
        chk({tag, ".gap_oe"}, 32'(ad_oe), 32'd0);
        tick();
        gen_dir_dato = 1'b1; gen_cs = 1'b0; gen_rd = wr; ad_in = rdval;
        settle();
        chk({tag, ".data_oe"}, 32'(ad_oe), 32'(wr));
        chk({tag, ".data_out"}, 32'(ad_out), wr ? 32'(wdata) : 32'd0);
        tick();
        gen_cs = 1'b1; gen_rd = 1'b1; ad_in = 8'hAA;
        settle();
        chk({tag, ".data_end_oe"}, 32'(ad_oe), 32'(wr));
        tick();
        gen_dir_dato = 1'b0; gen_flag_done = 1'b1;
        settle();
        chk({tag, ".no_early_rsp"}, 32'(rsp_valid), 32'd0);
        tick();
        gen_flag_done = 1'b0;
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".rsp_write"}, 32'(rsp_write), 32'(wr));
        chk({tag, ".rsp_error"}, 32'(rsp_error), 32'd0);
        if (!wr) chk({tag, ".rsp_rdata"}, 32'(rsp_rdata), 32'(rdval));
        chk({tag, ".rec0_reset"}, 32'(gen_reset), 32'd1);
        tick();
        chk({tag, ".rsp_single"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".rec1_reset"}, 32'(gen_reset), 32'd1);
        tick();
        chk({tag, ".idle_reset"}, 32'(gen_reset), 32'd0);
        chk({tag, ".idle_sel"}, 32'(gen_escribir_leer), 32'd0);
    endtask

    initial begin
        reset_count = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        ad_in = '0;
        gen_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.gen_reset", 32'(gen_reset), 32'd1);
        chk("rst.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst.busy", 32'(busy), 32'd1);
        chk("rst.en", 32'(gen_en_funcion), 32'd0);
        chk("rst.sel", 32'(gen_escribir_leer), 32'd0);
        chk("rst.ad_oe", 32'(ad_oe), 32'd0);
        chk("rst.ad_out", 32'(ad_out), 32'd0);
        chk("rst.rsp", 32'({rsp_valid, rsp_write, rsp_error, rsp_rdata}), 32'd0);
        reset_count = 1'b0;
        settle();
        chk("rel.reset0", 32'(gen_reset), 32'd1);
        tick();
        chk("rel.reset1", 32'(gen_reset), 32'd1);
        tick();
        chk("rel.idle_reset", 32'(gen_reset), 32'd0);
        chk("rel.idle_busy", 32'(busy), 32'd0);

        // 1: single write
        offer(1'b1, 8'h21, 8'h45);
        tick();
        cmd_valid = 1'b0;
        settle();
        chk("t1.busy", 32'(busy), 32'd1);
        chk("t1.no_bypass", 32'(gen_en_funcion), 32'd0);
        expect_launch(1'b1, "t1");
        gen_txn(1'b1, 8'h21, 8'h45, 8'h00, "t1");
        chk("t1.done_busy", 32'(busy), 32'd0);

        // 2: single read
        offer(1'b0, 8'h22, 8'h00);
        tick();
        cmd_valid = 1'b0;
        expect_launch(1'b0, "t2");
        gen_txn(1'b0, 8'h22, 8'h00, 8'h59, "t2");

        // 3: five back-to-back commands, full-FIFO rejection during pop
        offer(1'b0, 8'h10, 8'h00);
        tick();
        chk("t3.ready_c1", 32'(cmd_ready), 32'd1);
        offer(1'b0, 8'h11, 8'h00);
        tick();
        chk("t3.launch0", 32'(gen_en_funcion), 32'd1);
        offer(1'b1, 8'h12, 8'hC2);
        tick();
        offer(1'b0, 8'h13, 8'h00);
        tick();
        chk("t3.ready_c4", 32'(cmd_ready), 32'd1);
        offer(1'b0, 8'h14, 8'h00);
        tick();
        chk("t3.full", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        gen_txn(1'b0, 8'h10, 8'h00, 8'h80, "t3a");
        chk("t3.full_at_pop", 32'(cmd_ready), 32'd0);
        offer(1'b0, 8'hEE, 8'h00);
        tick();
        chk("t3.ready_back", 32'(cmd_ready), 32'd1);
        chk("t3.launch1", 32'(gen_en_funcion), 32'd1);
        cmd_valid = 1'b0;
        gen_txn(1'b0, 8'h11, 8'h00, 8'h81, "t3b");
        expect_launch(1'b1, "t3c");
        gen_txn(1'b1, 8'h12, 8'hC2, 8'h00, "t3c");
        expect_launch(1'b0, "t3d");
        gen_txn(1'b0, 8'h13, 8'h00, 8'h83, "t3d");
        expect_launch(1'b0, "t3e");
        gen_txn(1'b0, 8'h14, 8'h00, 8'h84, "t3e");
        chk("t3.drained", 32'(busy), 32'd0);

        // 4: generator never finishes -> timeout, then queued write launches
        offer(1'b0, 8'h30, 8'h00);
        tick();
        offer(1'b1, 8'h31, 8'h5A);
        tick();
        chk("t4.launch", 32'(gen_en_funcion), 32'd1);
        cmd_valid = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (k == 5) begin
                gen_dir_dato = 1'b1; gen_cs = 1'b0; gen_rd = 1'b0; ad_in = 8'h77;
            end else if (k == 6) begin
                gen_idle();
            end
            chk("t4.wait_no_rsp", 32'(rsp_valid), 32'd0);
        end
        tick();
        chk("t4.rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t4.rsp_error", 32'(rsp_error), 32'd1);
        chk("t4.rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("t4.rsp_write", 32'(rsp_write), 32'd0);
        chk("t4.rec0", 32'(gen_reset), 32'd1);
        tick();
        chk("t4.rec1", 32'(gen_reset), 32'd1);
        tick();
        chk("t4.idle", 32'(gen_reset), 32'd0);
        expect_launch(1'b1, "t4n");
        gen_txn(1'b1, 8'h31, 8'h5A, 8'h00, "t4n");

        // 6: flag_done on the timeout cycle wins
        offer(1'b0, 8'h40, 8'h00);
        tick();
        cmd_valid = 1'b0;
        expect_launch(1'b0, "t6");
        for (int k = 1; k <= 31; k++) begin
            tick();
            if (k == 10) begin
                gen_dir_dato = 1'b1; gen_cs = 1'b0; gen_rd = 1'b0; ad_in = 8'h3C;
            end else if (k == 11) begin
                gen_idle();
            end
        end
        tick();
        gen_flag_done = 1'b1;
        settle();
        chk("t6.no_early_rsp", 32'(rsp_valid), 32'd0);
        tick();
        gen_flag_done = 1'b0;
        chk("t6.rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t6.rsp_error", 32'(rsp_error), 32'd0);
        chk("t6.rsp_rdata", 32'(rsp_rdata), 32'h3C);
        tick();
        tick();
        chk("t6.idle", 32'(gen_reset), 32'd0);

        // 5: reset during a write data phase with two commands queued
        offer(1'b1, 8'h50, 8'hA5);
        tick();
        offer(1'b0, 8'h51, 8'h00);
        tick();
        chk("t5.launch", 32'(gen_en_funcion), 32'd1);
        offer(1'b0, 8'h52, 8'h00);
        tick();
        cmd_valid = 1'b0;
        gen_a_d = 1'b0; gen_cs = 1'b0; gen_dir_dato = 1'b0;
        tick();
        gen_a_d = 1'b1; gen_dir_dato = 1'b1;
        settle();
        chk("t5.data_oe", 32'(ad_oe), 32'd1);
        chk("t5.data_out", 32'(ad_out), 32'hA5);
        reset_count = 1'b1;
        settle();
        chk("t5.rst_oe", 32'(ad_oe), 32'd0);
        chk("t5.rst_out", 32'(ad_out), 32'd0);
        chk("t5.rst_gen_reset", 32'(gen_reset), 32'd1);
        chk("t5.rst_ready", 32'(cmd_ready), 32'd1);
        chk("t5.rst_sel", 32'(gen_escribir_leer), 32'd0);
        chk("t5.rst_rsp", 32'(rsp_valid), 32'd0);
        gen_idle();
        tick();
        reset_count = 1'b0;
        settle();
        chk("t5.rel_reset0", 32'(gen_reset), 32'd1);
        tick();
        chk("t5.rel_reset1", 32'(gen_reset), 32'd1);
        chk("t5.rel_rsp", 32'(rsp_valid), 32'd0);
        tick();
        chk("t5.idle_reset", 32'(gen_reset), 32'd0);
        chk("t5.idle_busy", 32'(busy), 32'd0);
        tick();
        chk("t5.no_launch", 32'(gen_en_funcion), 32'd0);
        chk("t5.still_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
